// File: rtl/servo_pwm_posicao_if.sv
// servo_pwm_posicao_if: control/status bundle of the servo PWM generator.
//   master drives  : ligar (enable), posicao (position index 0..7)
//   master samples : pwm, fim_periodo, em_movimento, db_largura (W = $clog2(PERIODO))
interface servo_pwm_posicao_if #(
    parameter int PERIODO = 1_000_000
);
    localparam int W = $clog2(PERIODO);

    logic         ligar;
    logic [2:0]   posicao;
    logic         pwm;
    logic         fim_periodo;
    logic         em_movimento;
    logic [W-1:0] db_largura;

    modport master (
        output ligar, posicao,
        input  pwm, fim_periodo, em_movimento, db_largura
    );

    modport slave (
        input  ligar, posicao,
        output pwm, fim_periodo, em_movimento, db_largura
    );
endinterface

// File: rtl/servo_pwm_posicao.sv
// servo_pwm_posicao: 3-bit position index to servo PWM, width LARG_MIN + posicao*LARG_PASSO.
//   i_clock            system clock, rising edge
//   i_clr              asynchronous reset, active-low
//   bus.ligar          enable; 0 = PWM off, counter held at 0, width snaps to target
//   bus.posicao        requested position index
//   bus.pwm            registered servo PWM output
//   bus.fim_periodo    registered one-cycle pulse on the last cycle of each period
//   bus.em_movimento   applied width differs from target width
//   bus.db_largura     applied pulse width (debug)
//   Optional macro SERVO_RAMPA_EN: width slews toward the target by at most
//   RAMPA_PASSO per period instead of jumping.
module servo_pwm_posicao #(
    parameter int PERIODO     = 1_000_000,
    parameter int LARG_MIN    = 50_000,
    parameter int LARG_PASSO  = 7_143,
    parameter int RAMPA_PASSO = 1_000
) (
    input  logic                  i_clock,
    input  logic                  i_clr,
    servo_pwm_posicao_if.slave    bus
);
    localparam int W = $clog2(PERIODO);
    localparam logic [W-1:0] L_MIN   = W'(LARG_MIN);
    localparam logic [W-1:0] L_PASSO = W'(LARG_PASSO);
    localparam logic [W-1:0] C_ULT   = W'(PERIODO - 1);

    // The widest pulse must leave at least one low cycle, and a zero ramp step would freeze the servo.
    if (LARG_MIN + 7 * LARG_PASSO >= PERIODO || RAMPA_PASSO < 1) begin : g_erro
        $error("ERRO: configuracao invalida do servo_pwm_posicao");
    end

    logic [W-1:0] r_cnt;
    logic [W-1:0] r_largura;
    logic         r_pwm;
    logic         r_fim;
    logic [W-1:0] w_alvo;
    logic [W-1:0] w_prox;
    logic         w_ultimo;

    assign w_alvo   = L_MIN + W'(bus.posicao) * L_PASSO;
    assign w_ultimo = (r_cnt == C_ULT);

`ifdef SERVO_RAMPA_EN
    logic         w_sobe;
    logic [W-1:0] w_dif;

    // Step is clamped to the remaining distance so the width lands exactly on the target.
    always_comb begin
        w_sobe = w_alvo > r_largura;
        w_dif  = w_sobe ? w_alvo - r_largura : r_largura - w_alvo;
        w_prox = (int'(w_dif) <= RAMPA_PASSO) ? w_alvo :
                 w_sobe ? r_largura + W'(RAMPA_PASSO) : r_largura - W'(RAMPA_PASSO);
    end
`else
    assign w_prox = w_alvo;
`endif

    // Width is only reloaded on the wrap edge, so a period in progress is never reshaped.
    always_ff @(posedge i_clock or negedge i_clr) begin
        if (!i_clr) begin
            r_cnt     <= '0;
            r_pwm     <= 1'b0;
            r_fim     <= 1'b0;
            r_largura <= L_MIN;
        end else if (!bus.ligar) begin
            r_cnt     <= '0;
            r_pwm     <= 1'b0;
            r_fim     <= 1'b0;
            r_largura <= w_alvo;
        end else begin
            r_cnt <= w_ultimo ? '0 : r_cnt + 1'b1;
            r_pwm <= r_cnt < r_largura;
            r_fim <= w_ultimo;
            if (w_ultimo)
                r_largura <= w_prox;
        end
    end

    assign bus.pwm          = r_pwm;
    assign bus.fim_periodo  = r_fim;
    assign bus.em_movimento = r_largura != w_alvo;
    assign bus.db_largura   = r_largura;
endmodule

// File: tb/tb_servo_pwm_posicao.sv
// tb_servo_pwm_posicao: randomized self-checking bench against a per-period width model.
module tb_servo_pwm_posicao;
    localparam int P  = 100;
    localparam int LM = 10;
    localparam int LP = 5;
    localparam int RP = 10;

    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    servo_pwm_posicao_if #(.PERIODO(P)) bus();

    servo_pwm_posicao #(
        .PERIODO(P), .LARG_MIN(LM), .LARG_PASSO(LP), .RAMPA_PASSO(RP)
    ) dut (
        .i_clock(clk),
        .i_clr  (clr),
        .bus    (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    int m_larg;

    function automatic int alvo(input int p);
        return LM + p * LP;
    endfunction

    // Width applied in the following period, given the current one and the target.
    function automatic int nxt(input int l, input int a);
`ifdef SERVO_RAMPA_EN
        if (a > l) return (a - l <= RP) ? a : l + RP;
        return (l - a <= RP) ? a : l - RP;
`else
        return a;
`endif
    endfunction

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    // Hold ligar=0 long enough for cnt=0 and the width to snap, then enable.
    task automatic iniciar(input int pos);
        bus.ligar   = 1'b0;
        bus.posicao = 3'(pos);
        edge1();
        edge1();
        m_larg = alvo(pos);
        n_cmp++;
        if (bus.db_largura !== m_larg) begin
            n_err++;
            $display("FAIL snap_largura: obtido=%0d esperado=%0d", bus.db_largura, m_larg);
        end
        bus.ligar = 1'b1;
    endtask

    // One full period: sample j after the j-th edge; cnt==P-1 occurs at edge P.
    task automatic periodo(input int muda_em, input int nova);
        int altos;
        int exp_db;
        altos = 0;
        for (int j = 1; j <= P; j++) begin
            edge1();
            exp_db = (j == P) ? nxt(m_larg, alvo(int'(bus.posicao))) : m_larg;
            n_cmp++;
            if (bus.pwm !== ((j - 1) < m_larg)) begin
                n_err++;
                $display("FAIL pwm j=%0d: obtido=%b esperado=%b", j, bus.pwm, (j - 1) < m_larg);
            end
            n_cmp++;
            if (bus.fim_periodo !== (j == P)) begin
                n_err++;
                $display("FAIL fim_periodo j=%0d: obtido=%b esperado=%b", j, bus.fim_periodo, j == P);
            end
            n_cmp++;
            if (bus.db_largura !== exp_db) begin
                n_err++;
                $display("FAIL db_largura j=%0d: obtido=%0d esperado=%0d", j, bus.db_largura, exp_db);
            end
            n_cmp++;
            if (bus.em_movimento !== (exp_db != alvo(int'(bus.posicao)))) begin
                n_err++;
                $display("FAIL em_movimento j=%0d: obtido=%b esperado=%b", j, bus.em_movimento,
                         exp_db != alvo(int'(bus.posicao)));
            end
            if (bus.pwm === 1'b1) altos++;
            if (j == muda_em) bus.posicao = 3'(nova);
        end
        n_cmp++;
        if (altos != m_larg) begin
            n_err++;
            $display("FAIL largura_periodo: obtido=%0d esperado=%0d", altos, m_larg);
        end
        m_larg = exp_db;
    endtask

    task automatic test_reset();
        clr         = 1'b0;
        bus.ligar   = 1'b0;
        bus.posicao = 3'd0;
        #12;
        n_cmp++;
        if (bus.pwm !== 1'b0 || bus.fim_periodo !== 1'b0 || bus.db_largura !== LM) begin
            n_err++;
            $display("FAIL reset_inicial: pwm=%b fim=%b larg=%0d esperado 0 0 %0d",
                     bus.pwm, bus.fim_periodo, bus.db_largura, LM);
        end
        @(negedge clk);
        clr = 1'b1;
        iniciar(4);
        for (int k = 0; k < 5; k++) edge1();
        n_cmp++;
        if (bus.pwm !== 1'b1) begin
            n_err++;
            $display("FAIL pwm_antes_reset: obtido=%b esperado=1", bus.pwm);
        end
        #3;
        clr = 1'b0;
        #1;
        n_cmp++;
        if (bus.pwm !== 1'b0 || bus.fim_periodo !== 1'b0 || bus.db_largura !== LM) begin
            n_err++;
            $display("FAIL reset_assincrono: pwm=%b fim=%b larg=%0d esperado 0 0 %0d",
                     bus.pwm, bus.fim_periodo, bus.db_largura, LM);
        end
        bus.ligar = 1'b0;
        @(negedge clk);
        clr = 1'b1;
    endtask

    task automatic test_basico();
        iniciar(3);
        for (int k = 0; k < 3; k++) periodo(-1, 0);
    endtask

    task automatic test_mudanca();
        periodo(40, 7);
        periodo(-1, 0);
    endtask

    task automatic test_ligar_off();
        for (int j = 1; j <= 12; j++) begin
            edge1();
            n_cmp++;
            if (bus.pwm !== ((j - 1) < m_larg)) begin
                n_err++;
                $display("FAIL pwm_parcial j=%0d: obtido=%b esperado=%b", j, bus.pwm, (j - 1) < m_larg);
            end
        end
        bus.ligar = 1'b0;
        for (int k = 0; k < P + 5; k++) begin
            edge1();
            n_cmp++;
            if (bus.pwm !== 1'b0 || bus.fim_periodo !== 1'b0) begin
                n_err++;
                $display("FAIL desligado k=%0d: pwm=%b fim=%b esperado 0 0", k, bus.pwm, bus.fim_periodo);
            end
        end
        m_larg = alvo(int'(bus.posicao));
        n_cmp++;
        if (bus.db_largura !== m_larg) begin
            n_err++;
            $display("FAIL larg_desligado: obtido=%0d esperado=%0d", bus.db_largura, m_larg);
        end
        bus.ligar = 1'b1;
        periodo(-1, 0);
    endtask

    task automatic test_salto();
        iniciar(0);
        bus.posicao = 3'd7;
        for (int k = 0; k < 6; k++) periodo(-1, 0);
        n_cmp++;
        if (bus.em_movimento !== 1'b0 || bus.db_largura !== alvo(7)) begin
            n_err++;
            $display("FAIL salto_final: mov=%b larg=%0d esperado 0 %0d",
                     bus.em_movimento, bus.db_largura, alvo(7));
        end
    endtask

    task automatic test_aleatorio();
        iniciar(int'($urandom_range(0, 7)));
        for (int k = 0; k < 12; k++) begin
            if ($urandom_range(0, 3) == 0) periodo(-1, 0);
            else periodo(int'($urandom_range(1, P - 1)), int'($urandom_range(0, 7)));
        end
    endtask

    initial begin
        test_reset();
        test_basico();
        test_mudanca();
        test_ligar_off();
        test_salto();
        test_aleatorio();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
